mdu_seq: RTL and testbench

//   Sequential multiply/divide unit: multi-cycle counterpart to the combinational ALU for mulw/mulhw/mulhwu/divw/divwu/modw/modwu.

---
 rtl/mdu_seq.sv | 198 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit for mulw/mulhw/mulhwu/divw/divwu/modw/modwu.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, followed
// by a sign-fix cycle. Valid/ready request in, valid/ready result out.
// Optional feature: define MDU_FAST_ZERO_EN to short-circuit divide-by-zero and
// multiply-by-zero straight to the sign-fix stage (same results, shorter latency).
module mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             busy
);

  // ALUOp codes for the MDU ops, continuing after the base ALU encodings.
  localparam logic [4:0] OpMulw   = 5'b10010;
  localparam logic [4:0] OpMulhw  = 5'b10011;
  localparam logic [4:0] OpMulhwu = 5'b10100;
  localparam logic [4:0] OpDivw   = 5'b10101;
  localparam logic [4:0] OpDivwu  = 5'b10110;
  localparam logic [4:0] OpModw   = 5'b10111;
  localparam logic [4:0] OpModwu  = 5'b11000;

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  function automatic logic op_is_mul(input logic [4:0] op);
    return (op == OpMulw) || (op == OpMulhw) || (op == OpMulhwu);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == OpDivw) || (op == OpDivwu) || (op == OpModw) || (op == OpModwu);
  endfunction

  function automatic logic op_is_signed(input logic [4:0] op);
    return (op == OpMulw) || (op == OpMulhw) || (op == OpDivw) || (op == OpModw);
  endfunction

  state_e                 state_q, state_d;
  logic [4:0]             op_q, op_d;
  logic [WIDTH-1:0]       m_q, m_d;        // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0]     acc_q, acc_d;    // mul: {hi, lo/multiplier}; div: {rem, quotient}
  logic                   sign_q, sign_d;  // product / quotient sign
  logic                   sign_a_q, sign_a_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]       c_q, c_d;
  logic                   hold_q, hold_d;  // extra FIX cycle on the skip path

  // Request decode and operand magnitudes.
  logic             in_mul, in_div, in_sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign in_mul = op_is_mul(ALUOp);
  assign in_div = op_is_div(ALUOp);
  assign in_sgn = op_is_signed(ALUOp);
  assign abs_a  = (in_sgn && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign abs_b  = (in_sgn && B[WIDTH-1]) ? (~B + 1'b1) : B;

`ifdef MDU_FAST_ZERO_EN
  logic zero_skip;
  assign zero_skip = in_div ? (B == '0) : (in_mul && ((A == '0) || (B == '0)));
`endif

  // One shift-add multiply step: add multiplicand if multiplier LSB set, shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step: shift in next dividend bit, keep difference if non-negative.
  logic [WIDTH:0]       rem_sh, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, m_q};
  assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign correction and result select for the FIX stage.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res;
  assign prod_fix = sign_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = sign_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  // Result mux; a zero divisor forces an all-ones quotient regardless of sign.
  always_comb begin
    res = '0;
    case (op_q)
      OpMulw:             res = prod_fix[WIDTH-1:0];
      OpMulhw, OpMulhwu:  res = prod_fix[2*WIDTH-1:WIDTH];
      OpDivw, OpDivwu:    res = (m_q == '0) ? '1 : quo_fix;
      OpModw, OpModwu:    res = rem_fix;
      default:            res = '0;
    endcase
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    m_d      = m_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    sign_a_d = sign_a_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    hold_d   = hold_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d     = ALUOp;
          sign_d   = in_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
          sign_a_d = in_sgn && A[WIDTH-1];
          cnt_d    = '0;
          hold_d   = 1'b0;
          if (in_mul) begin
            m_d     = abs_a;
            acc_d   = {{WIDTH{1'b0}}, abs_b};
            state_d = StBusy;
          end else if (in_div) begin
            m_d     = abs_b;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            state_d = StBusy;
          end else begin
            m_d     = '0;
            acc_d   = '0;
            hold_d  = 1'b1;
            state_d = StFix;
          end
`ifdef MDU_FAST_ZERO_EN
          // Preload the accumulator with what the iterations would have produced.
          if (zero_skip) begin
            acc_d   = in_div ? {abs_a, {WIDTH{1'b1}}} : '0;
            hold_d  = 1'b1;
            state_d = StFix;
          end
`endif
        end
      end
      StBusy: begin
        acc_d = op_is_mul(op_q) ? mul_next : div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          c_d     = res;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      op_q     <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      sign_a_q <= 1'b0;
      cnt_q    <= '0;
      c_q      <= '0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      sign_a_q <= sign_a_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      hold_q   <= hold_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign C         = c_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: results, latency, handshake hold and mid-op reset.
module tb_mdu_seq;

  localparam int unsigned W = 32;

  localparam logic [4:0] OpAdd    = 5'b00011;
  localparam logic [4:0] OpMulw   = 5'b10010;
  localparam logic [4:0] OpMulhw  = 5'b10011;
  localparam logic [4:0] OpMulhwu = 5'b10100;
  localparam logic [4:0] OpDivw   = 5'b10101;
  localparam logic [4:0] OpDivwu  = 5'b10110;
  localparam logic [4:0] OpModw   = 5'b10111;
  localparam logic [4:0] OpModwu  = 5'b11000;

  localparam int FullLat = W + 1;
`ifdef MDU_FAST_ZERO_EN
  localparam int ZeroLat = 2;
`else
  localparam int ZeroLat = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rstn, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]   alu_op;
  logic [W-1:0] a, b, c;

  int n_checks = 0;
  int n_errors = 0;

  mdu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUOp    (alu_op),
    .A        (a),
    .B        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .C        (c),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for the result, check value and latency, retire if out_ready.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_c, input int exp_lat);
    int lat;
    logic rdy_seen;
    alu_op   = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    check_eq({tag, " in_ready idle"}, W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_op   = OpMulw;
    check_eq({tag, " busy"}, W'(busy), W'(1));
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " latency"}, W'(lat), W'(exp_lat));
    check_eq({tag, " C"}, c, exp_c);
    check_eq({tag, " in_ready low while busy"}, W'(rdy_seen | in_ready), W'(0));
    if (out_ready) begin
      @(posedge clk); #1;
      check_eq({tag, " retired"}, W'({out_valid, in_ready}), W'(2'b01));
    end
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = '0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset outputs", W'({in_ready, out_valid, busy}), W'(3'b100));
    check_eq("reset C", c, '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_op("mulw -7*6",       OpMulw,   32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFD6, FullLat);
    run_op("mulhwu max*max",  OpMulhwu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FullLat);
    run_op("mulhw -1*-1",     OpMulhw,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, FullLat);
    run_op("mulhw min*2",     OpMulhw,  32'h8000_0000, 32'd2,        32'hFFFF_FFFF, FullLat);
    run_op("mulw 0*123",      OpMulw,   32'd0,         32'd123,      32'h0000_0000, ZeroLat);
    run_op("divw -7/2",       OpDivw,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, FullLat);
    run_op("modw -7/2",       OpModw,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, FullLat);
    run_op("divw 7/-2",       OpDivw,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, FullLat);
    run_op("modw 7/-2",       OpModw,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, FullLat);
    run_op("divwu 100/7",     OpDivwu,  32'd100,       32'd7,        32'd14,        FullLat);
    run_op("modwu 100/7",     OpModwu,  32'd100,       32'd7,        32'd2,         FullLat);
    run_op("divw 5/0",        OpDivw,   32'd5,         32'd0,        32'hFFFF_FFFF, ZeroLat);
    run_op("modw 5/0",        OpModw,   32'd5,         32'd0,        32'd5,         ZeroLat);
    run_op("divw -5/0",       OpDivw,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, ZeroLat);
    run_op("modw -5/0",       OpModw,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, ZeroLat);
    run_op("divwu 9/0",       OpDivwu,  32'd9,         32'd0,        32'hFFFF_FFFF, ZeroLat);
    run_op("divw min/-1",     OpDivw,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FullLat);
    run_op("modw min/-1",     OpModw,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, FullLat);
    run_op("non-mdu add",     OpAdd,    32'd3,         32'd4,        32'h0000_0000, 2);

    // Result must hold in DONE while the consumer stalls; new requests are refused.
    out_ready = 1'b0;
    run_op("hold divwu", OpDivwu, 32'd100, 32'd7, 32'd14, FullLat);
    for (int i = 0; i < 5; i++) begin
      alu_op   = OpMulw;
      a        = 32'd1;
      b        = 32'd1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("hold C", c, 32'd14);
      check_eq("hold flags", W'({out_valid, in_ready, busy}), W'(3'b101));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("hold retire", W'({out_valid, in_ready}), W'(2'b01));
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold pulse ignored", W'({out_valid, busy}), W'(2'b00));

    // Reset in the middle of the BUSY iterations.
    alu_op   = OpDivwu;
    a        = 32'd100;
    b        = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_eq("midop reset flags", W'({in_ready, out_valid, busy}), W'(3'b100));
    check_eq("midop reset C", c, '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_op("after reset mulw", OpMulw, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, FullLat);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
